// File: rtl/module_adder_arb_pkg.sv
// rtl/module_adder_arb_pkg.sv - shared types and constants for the adder arbiter (stats under ADDER_ARB_STATS_EN)
package module_adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ANCHO_DEF  = 8;
  localparam int N_REQ_DEF  = 4;
  localparam int STAT_CNT_W = 16;

endpackage

// File: rtl/module_carry_look_ahead_adder.sv
// rtl/module_carry_look_ahead_adder.sv - unsigned carry-look-ahead adder, 4-bit lookahead groups
module module_carry_look_ahead_adder #(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  output logic [ANCHO:0]   s
);

  // Operands are zero-padded to whole 4-bit groups; padding bits never generate or propagate.
  localparam int NG = (ANCHO + 3) / 4;
  localparam int W  = NG * 4;

  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  // Group carries are flattened lookahead equations; groups chain through their carry-out.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[ANCHO-1:0] = a;
    b_ext[ANCHO-1:0] = b;
    g = a_ext & b_ext;
    p = a_ext ^ b_ext;
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign s = {c[ANCHO], p[ANCHO-1:0] ^ c[ANCHO-1:0]};

endmodule

// File: rtl/module_adder_arbiter.sv
// rtl/module_adder_arbiter.sv - round-robin sequencer sharing one CLA adder; ADDER_ARB_STATS_EN adds op/carry counters
module module_adder_arbiter
  import module_adder_arb_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int N_REQ = N_REQ_DEF,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [ANCHO-1:0] req_a [N_REQ],
  input  logic [ANCHO-1:0] req_b [N_REQ],
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output logic [ANCHO:0]   resp_sum
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] ops_count,
  output logic [STAT_CNT_W-1:0] carry_count
`endif
);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_q;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
  logic [ANCHO:0]   add_s;
  logic [ID_W:0]    pick;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             accept;
  logic             resp_hs;
  logic [ID_W-1:0]  ptr_next;

  // First valid requester at or after start, wrapping modulo N_REQ; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  start);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    int              j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(start) + i;
      if (j >= N_REQ) j = j - N_REQ;
      cand = ID_W'(j);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign pick       = rr_pick(req_valid, ptr);
  assign pick_found = pick[ID_W];
  assign pick_idx   = pick[ID_W-1:0];
  assign ptr_next   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);

  module_carry_look_ahead_adder #(
    .ANCHO(ANCHO)
  ) u_cla (
    .a(op_a),
    .b(op_b),
    .s(add_s)
  );

  // Next-state and handshake decode; the grant is combinational so IDLE accepts in one cycle.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    resp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && !rst) begin
          req_ready[pick_idx] = 1'b1;
          accept              = 1'b1;
          next_state          = CALC;
        end
      end
      CALC: begin
        next_state = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_hs    = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, operand/owner capture, sum capture and rotating pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      id_q     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      resp_sum <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        op_a <= req_a[pick_idx];
        op_b <= req_b[pick_idx];
        id_q <= pick_idx;
      end
      if (state == CALC) begin
        resp_sum <= add_s;
      end
      if (resp_hs) begin
        ptr <= ptr_next;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;

`ifdef ADDER_ARB_STATS_EN
  // Wrapping counters of completed responses and of those that produced a carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_count   <= '0;
      carry_count <= '0;
    end else if (resp_hs) begin
      ops_count <= ops_count + STAT_CNT_W'(1);
      if (resp_sum[ANCHO]) begin
        carry_count <= carry_count + STAT_CNT_W'(1);
      end
    end
  end
`endif

endmodule
